spi_game_target: RTL and testbench

//  SPI mode-0 responder (target) on the far end of the soc's spi0 master. It gives the NIOS
//  a MAX3421E-style register window into the game fabric:
//  - Regs 0-15 are writable control bytes: keycodes, AI movement, game mode.
//  - Regs 16-31 are read-only status bytes: health, positions, lose flags.
//  All SPI inputs are oversampled in the Clk domain; there is no second clock.

---
 rtl/spi_tgt_pkg.sv | 23 ++
 rtl/spi_edge_sync.sv | 32 +++
 rtl/spi_game_target.sv | 134 +++++++++++++
 tb/tb_spi_game_target.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_tgt_pkg.sv
// Shared types and command-byte field positions for the SPI game target.
package spi_tgt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2
  } state_t;

  localparam int CMD_ADDR_HI = 7;
  localparam int CMD_ADDR_LO = 3;
  localparam int CMD_WR_BIT  = 1;
  localparam int REG_COUNT   = 32;

  function automatic logic [4:0] cmd_addr(input logic [7:0] cmd);
    return cmd[CMD_ADDR_HI:CMD_ADDR_LO];
  endfunction

  function automatic logic cmd_is_write(input logic [7:0] cmd);
    return cmd[CMD_WR_BIT];
  endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Synchronizer chain plus rise/fall detect for one asynchronous SPI pin.
// Latency: STAGES Clk to q; edge flags are combinational on q, one Clk wide.
module spi_edge_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic Clk,
  input  logic Reset,
  input  logic din,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      chain <= {STAGES{RST_VAL}};
      prev  <= RST_VAL;
    end else begin
      chain <= {chain[STAGES-2:0], din};
      prev  <= chain[STAGES-1];
    end
  end

  assign q    = chain[STAGES-1];
  assign rise = q & ~prev;
  assign fall = ~q & prev;

endmodule

// File: rtl/spi_game_target.sv
// SPI mode-0 target: 32-byte register window, regs 0..NUM_RW-1 writable, the rest status.
// Latency: SS_n fall to miso_oe SYNC_STAGES+1 Clk; no backpressure, the master paces all traffic.
module spi_game_target
  import spi_tgt_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_RW      = 16
) (
  input  logic                            Clk,
  input  logic                            Reset,
  input  logic                            spi_sclk,
  input  logic                            spi_ss_n,
  input  logic                            spi_mosi,
  output logic                            spi_miso,
  output logic                            miso_oe,
  input  logic [(REG_COUNT-NUM_RW)*8-1:0] status_in,
  output logic [NUM_RW*8-1:0]             ctrl_out,
  output logic                            wr_strobe,
  output logic [4:0]                      wr_addr,
  output logic                            busy
);

  localparam logic [5:0] RW_LIMIT = 6'(NUM_RW);

  logic sclk_q, sclk_rise, sclk_fall;
  logic ss_q, ss_rise, ss_fall;
  logic mosi_q, mosi_rise_unused, mosi_fall_unused;

  spi_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
    .Clk(Clk), .Reset(Reset), .din(spi_sclk),
    .q(sclk_q), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss_sync (
    .Clk(Clk), .Reset(Reset), .din(spi_ss_n),
    .q(ss_q), .rise(ss_rise), .fall(ss_fall)
  );

  spi_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi_sync (
    .Clk(Clk), .Reset(Reset), .din(spi_mosi),
    .q(mosi_q), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  state_t     state;
  logic [2:0] bit_cnt;
  logic [7:0] rx_shift;
  logic [7:0] tx_shift;
  logic [4:0] ptr;
  logic       wr_mode;
  logic       load_pend;
  logic [7:0] ctrl_q [NUM_RW];
  logic [7:0] all_regs [REG_COUNT];
  logic [7:0] rx_byte;
  logic       sclk_seen_unused;

  assign sclk_seen_unused = sclk_q;
  assign rx_byte = {rx_shift[6:0], mosi_q};

  for (genvar g = 0; g < REG_COUNT; g++) begin : g_regs
    if (g < NUM_RW) begin : g_rw
      assign all_regs[g] = ctrl_q[g];
    end else begin : g_ro
      assign all_regs[g] = status_in[(g-NUM_RW)*8 +: 8];
    end
  end

  for (genvar g = 0; g < NUM_RW; g++) begin : g_ctrl_out
    assign ctrl_out[g*8 +: 8] = ctrl_q[g];
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      bit_cnt   <= 3'd0;
      rx_shift  <= 8'd0;
      tx_shift  <= 8'd0;
      ptr       <= 5'd0;
      wr_mode   <= 1'b0;
      load_pend <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= 5'd0;
      for (int i = 0; i < NUM_RW; i++) ctrl_q[i] <= 8'd0;
    end else begin
      wr_strobe <= 1'b0;
      load_pend <= 1'b0;
      // Read data is fetched one cycle after ptr settles so the snapshot sees the new address.
      if (load_pend) tx_shift <= all_regs[ptr];
      case (state)
        IDLE: begin
          bit_cnt <= 3'd0;
          if (ss_fall) begin
            state    <= CMD;
            tx_shift <= all_regs[NUM_RW];
          end
        end
        default: begin
          if (ss_rise) begin
            state   <= IDLE;
            bit_cnt <= 3'd0;
          end else if (sclk_rise) begin
            rx_shift <= rx_byte;
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (state == CMD) begin
                state     <= DATA;
                ptr       <= cmd_addr(rx_byte);
                wr_mode   <= cmd_is_write(rx_byte);
                load_pend <= ~cmd_is_write(rx_byte);
              end else begin
                ptr <= ptr + 5'd1;
                if (!wr_mode) begin
                  load_pend <= 1'b1;
                end else if ({1'b0, ptr} < RW_LIMIT) begin
                  for (int i = 0; i < NUM_RW; i++)
                    if (ptr == 5'(i)) ctrl_q[i] <= rx_byte;
                  wr_strobe <= 1'b1;
                  wr_addr   <= ptr;
                end
              end
            end
          end else if (sclk_fall && bit_cnt != 3'd0) begin
            // The fall right after a byte boundary (or a mode-0 violating first fall) keeps the fresh MSB.
            tx_shift <= {tx_shift[6:0], 1'b0};
          end
        end
      endcase
    end
  end

  assign miso_oe  = (state != IDLE);
  assign busy     = (state != IDLE);
  assign spi_miso = ((state == CMD) || (state == DATA && !wr_mode)) ? tx_shift[7] : 1'b0;

endmodule

// File: tb/tb_spi_game_target.sv
// Bench for spi_game_target: bit-banged SPI master at Clk/10 with write/read scoreboards.
module tb_spi_game_target;

  logic         Clk = 1'b0;
  logic         Reset;
  logic         spi_sclk, spi_ss_n, spi_mosi;
  logic         spi_miso, miso_oe, wr_strobe, busy;
  logic [127:0] status_in;
  logic [127:0] ctrl_out;
  logic [4:0]   wr_addr;

  int n_checks = 0;
  int n_fail   = 0;

  logic [12:0] exp_wr[$];
  logic [12:0] obs_wr[$];
  logic [7:0]  exp_rd[$];

  spi_game_target #(.SYNC_STAGES(2), .NUM_RW(16)) dut (
    .Clk(Clk), .Reset(Reset),
    .spi_sclk(spi_sclk), .spi_ss_n(spi_ss_n), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .miso_oe(miso_oe),
    .status_in(status_in), .ctrl_out(ctrl_out),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr), .busy(busy)
  );

  always #10 Clk = ~Clk;

  always @(negedge Clk)
    if (wr_strobe === 1'b1) obs_wr.push_back({wr_addr, ctrl_out[8*wr_addr[3:0] +: 8]});

  task automatic spi_byte(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'd0;
    for (int i = 7; i > 7 - nbits; i--) begin
      spi_mosi = tx[i];
      repeat (5) @(negedge Clk);
      rx = {rx[6:0], spi_miso};
      spi_sclk = 1'b1;
      repeat (5) @(negedge Clk);
      spi_sclk = 1'b0;
    end
  endtask

  task automatic ss_begin();
    spi_ss_n = 1'b0;
    repeat (6) @(negedge Clk);
  endtask

  task automatic ss_end();
    repeat (5) @(negedge Clk);
    spi_ss_n = 1'b1;
    repeat (6) @(negedge Clk);
  endtask

  task automatic test_reset();
    n_checks++; if (ctrl_out !== 128'd0) begin n_fail++; $display("FAIL reset_ctrl_out: got %h expected 0", ctrl_out); end
    n_checks++; if (miso_oe !== 1'b0) begin n_fail++; $display("FAIL reset_miso_oe: got %b expected 0", miso_oe); end
    n_checks++; if (spi_miso !== 1'b0) begin n_fail++; $display("FAIL reset_spi_miso: got %b expected 0", spi_miso); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (wr_strobe !== 1'b0) begin n_fail++; $display("FAIL reset_wr_strobe: got %b expected 0", wr_strobe); end
    n_checks++; if (wr_addr !== 5'd0) begin n_fail++; $display("FAIL reset_wr_addr: got %0d expected 0", wr_addr); end
  endtask

  task automatic test_write_burst();
    logic [7:0]  rx;
    logic [12:0] e, o;
    obs_wr.delete();
    exp_wr.push_back({5'd0, 8'h1A});
    exp_wr.push_back({5'd1, 8'h16});
    ss_begin();
    spi_byte(8'h02, 8, rx);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL wr_busy: got %b expected 1", busy); end
    spi_byte(8'h1A, 8, rx);
    spi_byte(8'h16, 8, rx);
    ss_end();
    while (exp_wr.size() > 0) begin
      e = exp_wr.pop_front();
      n_checks++;
      if (obs_wr.size() == 0) begin n_fail++; $display("FAIL wr_strobe: got none expected addr %0d data %h", e[12:8], e[7:0]); end
      else begin
        o = obs_wr.pop_front();
        if (o !== e) begin n_fail++; $display("FAIL wr_strobe: got %h expected %h", o, e); end
      end
    end
    n_checks++; if (obs_wr.size() != 0) begin n_fail++; $display("FAIL wr_extra: got %0d extra strobes expected 0", obs_wr.size()); end
    n_checks++; if (ctrl_out[15:0] !== 16'h161A) begin n_fail++; $display("FAIL wr_ctrl01: got %h expected 161a", ctrl_out[15:0]); end
  endtask

  task automatic test_read();
    logic [7:0] rx, e;
    exp_rd.push_back(8'h3C);
    exp_rd.push_back(8'hA5);
    spi_ss_n = 1'b0;
    repeat (2) @(negedge Clk);
    n_checks++; if (miso_oe !== 1'b0) begin n_fail++; $display("FAIL rd_oe_early: got %b expected 0", miso_oe); end
    @(negedge Clk);
    n_checks++; if (miso_oe !== 1'b1) begin n_fail++; $display("FAIL rd_oe_latency: got %b expected 1", miso_oe); end
    repeat (3) @(negedge Clk);
    spi_byte(8'h88, 8, rx);
    e = exp_rd.pop_front();
    n_checks++; if (rx !== e) begin n_fail++; $display("FAIL rd_cmd_miso: got %h expected %h", rx, e); end
    spi_byte(8'h00, 8, rx);
    e = exp_rd.pop_front();
    n_checks++; if (rx !== e) begin n_fail++; $display("FAIL rd_reg17: got %h expected %h", rx, e); end
    ss_end();
    n_checks++; if (miso_oe !== 1'b0) begin n_fail++; $display("FAIL rd_oe_release: got %b expected 0", miso_oe); end
  endtask

  task automatic test_wrap();
    logic [7:0] rx, e;
    exp_rd.push_back(8'h3C);
    exp_rd.push_back(8'h5E);
    exp_rd.push_back(8'h1A);
    exp_rd.push_back(8'h16);
    ss_begin();
    spi_byte(8'hF8, 8, rx);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) spi_byte(8'h00, 8, rx);
      e = exp_rd.pop_front();
      n_checks++; if (rx !== e) begin n_fail++; $display("FAIL wrap_byte%0d: got %h expected %h", i, rx, e); end
    end
    ss_end();
  endtask

  task automatic test_abort();
    logic [7:0]  rx;
    logic [12:0] e, o;
    obs_wr.delete();
    ss_begin();
    spi_byte(8'h1A, 8, rx);
    spi_byte(8'hFF, 5, rx);
    ss_end();
    n_checks++; if (obs_wr.size() != 0) begin n_fail++; $display("FAIL abort_strobe: got %0d strobes expected 0", obs_wr.size()); end
    n_checks++; if (ctrl_out[31:24] !== 8'h00) begin n_fail++; $display("FAIL abort_ctrl3: got %h expected 00", ctrl_out[31:24]); end
    exp_wr.push_back({5'd3, 8'h77});
    ss_begin();
    spi_byte(8'h1A, 8, rx);
    spi_byte(8'h77, 8, rx);
    ss_end();
    e = exp_wr.pop_front();
    n_checks++;
    if (obs_wr.size() != 1) begin n_fail++; $display("FAIL abort_next: got %0d strobes expected 1", obs_wr.size()); end
    else begin
      o = obs_wr.pop_front();
      if (o !== e) begin n_fail++; $display("FAIL abort_next: got %h expected %h", o, e); end
    end
  endtask

  task automatic test_ro_write();
    logic [7:0] rx, e;
    obs_wr.delete();
    ss_begin();
    spi_byte(8'h82, 8, rx);
    spi_byte(8'hFF, 8, rx);
    ss_end();
    n_checks++; if (obs_wr.size() != 0) begin n_fail++; $display("FAIL ro_strobe: got %0d strobes expected 0", obs_wr.size()); end
    exp_rd.push_back(8'h3C);
    exp_rd.push_back(8'h3C);
    ss_begin();
    spi_byte(8'h80, 8, rx);
    e = exp_rd.pop_front();
    n_checks++; if (rx !== e) begin n_fail++; $display("FAIL ro_cmd_miso: got %h expected %h", rx, e); end
    spi_byte(8'h00, 8, rx);
    e = exp_rd.pop_front();
    n_checks++; if (rx !== e) begin n_fail++; $display("FAIL ro_reg16: got %h expected %h", rx, e); end
    ss_end();
  endtask

  task automatic test_ro_cross();
    logic [7:0]  rx;
    logic [12:0] e, o;
    obs_wr.delete();
    exp_wr.push_back({5'd15, 8'h40});
    exp_wr.push_back({5'd0, 8'h51});
    ss_begin();
    spi_byte(8'h7A, 8, rx);
    for (int i = 0; i < 18; i++) spi_byte(8'(8'h40 + i), 8, rx);
    ss_end();
    while (exp_wr.size() > 0) begin
      e = exp_wr.pop_front();
      n_checks++;
      if (obs_wr.size() == 0) begin n_fail++; $display("FAIL cross_strobe: got none expected %h", e); end
      else begin
        o = obs_wr.pop_front();
        if (o !== e) begin n_fail++; $display("FAIL cross_strobe: got %h expected %h", o, e); end
      end
    end
    n_checks++; if (obs_wr.size() != 0) begin n_fail++; $display("FAIL cross_extra: got %0d extra strobes expected 0", obs_wr.size()); end
    n_checks++; if (ctrl_out[7:0] !== 8'h51) begin n_fail++; $display("FAIL cross_ctrl0: got %h expected 51", ctrl_out[7:0]); end
    n_checks++; if (ctrl_out[127:120] !== 8'h40) begin n_fail++; $display("FAIL cross_ctrl15: got %h expected 40", ctrl_out[127:120]); end
  endtask

  task automatic test_async_reset();
    logic [7:0]  rx;
    logic [12:0] e, o;
    ss_begin();
    spi_byte(8'h02, 8, rx);
    spi_byte(8'hC3, 3, rx);
    @(negedge Clk);
    #3 Reset = 1'b1;
    #1;
    n_checks++; if (ctrl_out !== 128'd0) begin n_fail++; $display("FAIL arst_ctrl: got %h expected 0", ctrl_out); end
    n_checks++; if (busy !== 1'b0 || miso_oe !== 1'b0) begin n_fail++; $display("FAIL arst_busy_oe: got %b%b expected 00", busy, miso_oe); end
    n_checks++; if (spi_miso !== 1'b0 || wr_strobe !== 1'b0) begin n_fail++; $display("FAIL arst_miso_strobe: got %b%b expected 00", spi_miso, wr_strobe); end
    spi_ss_n = 1'b1;
    spi_sclk = 1'b0;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    repeat (5) @(negedge Clk);
    obs_wr.delete();
    exp_wr.push_back({5'd2, 8'h99});
    ss_begin();
    spi_byte(8'h12, 8, rx);
    spi_byte(8'h99, 8, rx);
    ss_end();
    e = exp_wr.pop_front();
    n_checks++;
    if (obs_wr.size() != 1) begin n_fail++; $display("FAIL arst_recover: got %0d strobes expected 1", obs_wr.size()); end
    else begin
      o = obs_wr.pop_front();
      if (o !== e) begin n_fail++; $display("FAIL arst_recover: got %h expected %h", o, e); end
    end
  endtask

  initial begin
    Reset     = 1'b1;
    spi_sclk  = 1'b0;
    spi_ss_n  = 1'b1;
    spi_mosi  = 1'b0;
    status_in = 128'd0;
    status_in[7:0]     = 8'h3C;
    status_in[15:8]    = 8'hA5;
    status_in[127:120] = 8'h5E;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    repeat (3) @(negedge Clk);
    test_reset();
    test_write_burst();
    test_read();
    test_wrap();
    test_abort();
    test_ro_write();
    test_ro_cross();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
